// File: rtl/weightbuffer_loader.sv
// Deserialises a narrow weight stream into a full KxKxN_I ternary set, drives the
// weight buffer write port (save/flush) and owns the double-buffer bank select.
module weightbuffer_loader #(
  parameter int N_I    = 512,
  parameter int K      = 3,
  parameter int WORD_W = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [WORD_W-1:0]                    s_data_i,
  input  logic                                 flush_req_i,
  input  logic                                 consumer_done_i,
  output logic [0:K-1][0:K-1][0:N_I-1][1:0]    data_o,
  output logic                                 save_enable_o,
  output logic                                 flush_o,
  output logic                                 read_set_o,
  output logic                                 set_valid_o
);

  localparam int BLOCK_W = K * K * N_I * 2;
  localparam int N_BEATS = BLOCK_W / WORD_W;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  generate
    if ((WORD_W > BLOCK_W) || ((BLOCK_W % WORD_W) != 0)) begin : g_bad_word_w
      $error("weightbuffer_loader: WORD_W must divide BLOCK_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    WRITE = 2'd2,
    PEND  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [BLOCK_W-1:0] set_data;
  logic               handshake;

  // Older beats move toward the MSBs, so beat 0 lands in data_o[0][0][0].
  function automatic logic [BLOCK_W-1:0] shift_in(input logic [BLOCK_W-1:0] cur,
                                                  input logic [WORD_W-1:0]  beat);
    return (cur << WORD_W) | BLOCK_W'(beat);
  endfunction

  assign s_ready_o = ~rst_i & (state == FILL) & ~flush_req_i;
  assign handshake = s_valid_i & s_ready_o;
  assign data_o    = set_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= FILL;
      beat_cnt      <= '0;
      set_data      <= '0;
      read_set_o    <= 1'b0;
      set_valid_o   <= 1'b0;
      save_enable_o <= 1'b0;
      flush_o       <= 1'b0;
    end else begin
      save_enable_o <= 1'b0;
      flush_o       <= 1'b0;
      case (state)
        FILL: begin
          if (consumer_done_i) set_valid_o <= 1'b0;
          if (flush_req_i) begin
            beat_cnt <= '0;
            flush_o  <= 1'b1;
            state    <= FLUSH;
          end else if (handshake) begin
            set_data <= shift_in(set_data, s_data_i);
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt      <= '0;
              save_enable_o <= 1'b1;
              state         <= WRITE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (consumer_done_i) set_valid_o <= 1'b0;
          state <= FILL;
        end
        WRITE: begin
          // A release seen here lets PEND swap on its first cycle.
          if (consumer_done_i) set_valid_o <= 1'b0;
          state <= PEND;
        end
        PEND: begin
          if (!set_valid_o || consumer_done_i) begin
            read_set_o  <= ~read_set_o;
            set_valid_o <= 1'b1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_weightbuffer_loader.sv
// Self-checking bench for weightbuffer_loader with N_I=4, K=1, WORD_W=4 (two beats per set).
module tb_weightbuffer_loader;

  logic                        clk;
  logic                        rst;
  logic                        s_valid;
  logic                        s_ready;
  logic [3:0]                  s_data;
  logic                        flush_req;
  logic                        consumer_done;
  logic [0:0][0:0][0:3][1:0]   data_o;
  logic                        save_enable;
  logic                        flush;
  logic                        read_set;
  logic                        set_valid;
  logic [7:0]                  data_flat;

  int n_cmp  = 0;
  int n_fail = 0;

  assign data_flat = data_o;

  weightbuffer_loader #(.N_I(4), .K(1), .WORD_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .s_data_i        (s_data),
    .flush_req_i     (flush_req),
    .consumer_done_i (consumer_done),
    .data_o          (data_o),
    .save_enable_o   (save_enable),
    .flush_o         (flush),
    .read_set_o      (read_set),
    .set_valid_o     (set_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b1; s_data = 4'h0; flush_req = 1'b0; consumer_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready got=%b want=0", s_ready); end
    n_cmp++; if (data_flat !== 8'h00)  begin n_fail++; $display("FAIL reset_data got=%h want=00", data_flat); end
    n_cmp++; if (read_set !== 1'b0)    begin n_fail++; $display("FAIL reset_read_set got=%b want=0", read_set); end
    n_cmp++; if (set_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_set_valid got=%b want=0", set_valid); end
    n_cmp++; if (save_enable !== 1'b0) begin n_fail++; $display("FAIL reset_save got=%b want=0", save_enable); end
    n_cmp++; if (flush !== 1'b0)       begin n_fail++; $display("FAIL reset_flush got=%b want=0", flush); end
    step();
    n_cmp++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready_held got=%b want=0", s_ready); end
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_basic();
    s_valid = 1'b1; s_data = 4'hA;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b want=1", s_ready); end
    step();
    s_data = 4'h5;
    step();
    s_valid = 1'b0;
    n_cmp++; if (save_enable !== 1'b1) begin n_fail++; $display("FAIL basic_save got=%b want=1", save_enable); end
    n_cmp++; if (data_flat !== 8'hA5)  begin n_fail++; $display("FAIL basic_data got=%h want=a5", data_flat); end
    n_cmp++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL basic_ready_write got=%b want=0", s_ready); end
    n_cmp++; if (read_set !== 1'b0)    begin n_fail++; $display("FAIL basic_rs_early got=%b want=0", read_set); end
    step();
    n_cmp++; if (save_enable !== 1'b0) begin n_fail++; $display("FAIL basic_save_width got=%b want=0", save_enable); end
    n_cmp++; if (read_set !== 1'b0)    begin n_fail++; $display("FAIL basic_rs_pend got=%b want=0", read_set); end
    step();
    n_cmp++; if (read_set !== 1'b1)    begin n_fail++; $display("FAIL basic_rs_swap got=%b want=1", read_set); end
    n_cmp++; if (set_valid !== 1'b1)   begin n_fail++; $display("FAIL basic_set_valid got=%b want=1", set_valid); end
    n_cmp++; if (s_ready !== 1'b1)     begin n_fail++; $display("FAIL basic_ready_refill got=%b want=1", s_ready); end
  endtask

  task automatic test_pend_hold();
    s_valid = 1'b1; s_data = 4'h3;
    step();
    s_data = 4'hC;
    step();
    s_valid = 1'b0;
    n_cmp++; if (save_enable !== 1'b1) begin n_fail++; $display("FAIL hold_save got=%b want=1", save_enable); end
    n_cmp++; if (data_flat !== 8'h3C)  begin n_fail++; $display("FAIL hold_data got=%h want=3c", data_flat); end
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL hold_ready[%0d] got=%b want=0", i, s_ready); end
      n_cmp++; if (read_set !== 1'b1) begin n_fail++; $display("FAIL hold_rs[%0d] got=%b want=1", i, read_set); end
      step();
    end
    consumer_done = 1'b1;
    step();
    consumer_done = 1'b0;
    n_cmp++; if (read_set !== 1'b0)  begin n_fail++; $display("FAIL hold_rs_swap got=%b want=0", read_set); end
    n_cmp++; if (set_valid !== 1'b1) begin n_fail++; $display("FAIL hold_set_valid got=%b want=1", set_valid); end
    n_cmp++; if (s_ready !== 1'b1)   begin n_fail++; $display("FAIL hold_ready_refill got=%b want=1", s_ready); end
  endtask

  task automatic test_flush();
    s_valid = 1'b1; s_data = 4'hF;
    step();
    s_valid = 1'b0; flush_req = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_req got=%b want=0", s_ready); end
    step();
    n_cmp++; if (flush !== 1'b1)       begin n_fail++; $display("FAIL flush_pulse got=%b want=1", flush); end
    n_cmp++; if (save_enable !== 1'b0) begin n_fail++; $display("FAIL flush_save got=%b want=0", save_enable); end
    n_cmp++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL flush_ready got=%b want=0", s_ready); end
    n_cmp++; if (read_set !== 1'b0)    begin n_fail++; $display("FAIL flush_rs got=%b want=0", read_set); end
    step();
    flush_req = 1'b0;
    n_cmp++; if (flush !== 1'b0)     begin n_fail++; $display("FAIL flush_width got=%b want=0", flush); end
    n_cmp++; if (set_valid !== 1'b1) begin n_fail++; $display("FAIL flush_set_valid got=%b want=1", set_valid); end
    step();
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL flush_single got=%b want=0", flush); end
    s_valid = 1'b1; s_data = 4'h1;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got=%b want=1", s_ready); end
    step();
    s_data = 4'h2;
    step();
    s_valid = 1'b0;
    n_cmp++; if (save_enable !== 1'b1) begin n_fail++; $display("FAIL flush_refill_save got=%b want=1", save_enable); end
    n_cmp++; if (data_flat !== 8'h12)  begin n_fail++; $display("FAIL flush_refill_data got=%h want=12", data_flat); end
    consumer_done = 1'b1;
    step();
    consumer_done = 1'b0;
    n_cmp++; if (set_valid !== 1'b0) begin n_fail++; $display("FAIL write_release got=%b want=0", set_valid); end
    step();
    n_cmp++; if (read_set !== 1'b1)  begin n_fail++; $display("FAIL write_release_swap got=%b want=1", read_set); end
    n_cmp++; if (set_valid !== 1'b1) begin n_fail++; $display("FAIL write_release_sv got=%b want=1", set_valid); end
  endtask

  task automatic test_release();
    consumer_done = 1'b1;
    step();
    consumer_done = 1'b0;
    n_cmp++; if (set_valid !== 1'b0) begin n_fail++; $display("FAIL release_fill got=%b want=0", set_valid); end
    n_cmp++; if (read_set !== 1'b1)  begin n_fail++; $display("FAIL release_rs got=%b want=1", read_set); end
    consumer_done = 1'b1;
    step();
    consumer_done = 1'b0;
    n_cmp++; if (set_valid !== 1'b0) begin n_fail++; $display("FAIL release_ignored got=%b want=0", set_valid); end
    n_cmp++; if (read_set !== 1'b1)  begin n_fail++; $display("FAIL release_ignored_rs got=%b want=1", read_set); end
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] beat;
    logic       hs;
    logic       last_rs;
    logic       pending;
    int         sets;
    int         toggles;
    sets = 0; toggles = 0; pending = 1'b0; last_rs = read_set;
    for (int cyc = 0; cyc < 3000 && sets < 20; cyc++) begin
      s_valid       = 1'($urandom_range(0, 1));
      s_data        = 4'($urandom);
      consumer_done = !consumer_done && ($urandom_range(0, 3) == 0);
      hs   = s_valid && s_ready;
      beat = s_data;
      step();
      if (hs) q.push_back(beat);
      if (read_set !== last_rs) begin
        toggles++;
        last_rs = read_set;
        n_cmp++; if (pending !== 1'b1)  begin n_fail++; $display("FAIL rand_swap_unexpected cyc=%0d got=swap want=none", cyc); end
        n_cmp++; if (set_valid !== 1'b1) begin n_fail++; $display("FAIL rand_swap_sv cyc=%0d got=%b want=1", cyc, set_valid); end
        pending = 1'b0;
      end
      n_cmp++; if ((save_enable && flush) || flush) begin n_fail++; $display("FAIL rand_excl cyc=%0d save=%b flush=%b want flush=0", cyc, save_enable, flush); end
      if (save_enable === 1'b1) begin
        n_cmp++;
        if (q.size() < 2) begin
          n_fail++; $display("FAIL rand_beats cyc=%0d got=%0d queued want>=2", cyc, q.size());
        end else begin
          if (data_flat !== {q[0], q[1]}) begin n_fail++; $display("FAIL rand_set%0d got=%h want=%h", sets, data_flat, {q[0], q[1]}); end
          void'(q.pop_front());
          void'(q.pop_front());
        end
        sets++;
        pending = 1'b1;
      end
      if (pending) begin
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rand_ready_pending cyc=%0d got=%b want=0", cyc, s_ready); end
      end
    end
    n_cmp++; if (sets != 20) begin n_fail++; $display("FAIL rand_sets got=%0d want=20", sets); end
    s_valid = 1'b0; consumer_done = 1'b1;
    step();
    consumer_done = 1'b0;
    n_cmp++; if (set_valid !== 1'b0) begin n_fail++; $display("FAIL rand_final_release got=%b want=0", set_valid); end
    step();
    if (read_set !== last_rs) toggles++;
    n_cmp++; if (toggles != 20)      begin n_fail++; $display("FAIL rand_swaps got=%0d want=20", toggles); end
    n_cmp++; if (set_valid !== 1'b1) begin n_fail++; $display("FAIL rand_final_sv got=%b want=1", set_valid); end
    n_cmp++; if (q.size() != 0)      begin n_fail++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1; s_data = 4'h9;
    step();
    s_data = 4'h6;
    step();
    s_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL ar_pend_ready got=%b want=0", s_ready); end
    n_cmp++; if (read_set !== 1'b1)   begin n_fail++; $display("FAIL ar_pend_rs got=%b want=1", read_set); end
    n_cmp++; if (data_flat !== 8'h96) begin n_fail++; $display("FAIL ar_pend_data got=%h want=96", data_flat); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL ar_ready got=%b want=0", s_ready); end
    n_cmp++; if (data_flat !== 8'h00)  begin n_fail++; $display("FAIL ar_data got=%h want=00", data_flat); end
    n_cmp++; if (read_set !== 1'b0)    begin n_fail++; $display("FAIL ar_rs got=%b want=0", read_set); end
    n_cmp++; if (set_valid !== 1'b0)   begin n_fail++; $display("FAIL ar_sv got=%b want=0", set_valid); end
    n_cmp++; if (save_enable !== 1'b0) begin n_fail++; $display("FAIL ar_save got=%b want=0", save_enable); end
    n_cmp++; if (flush !== 1'b0)       begin n_fail++; $display("FAIL ar_flush got=%b want=0", flush); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_after got=%b want=1", s_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pend_hold();
    test_flush();
    test_release();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
